// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched from an external store via oKeyIdx.
// Optional abort input is enabled by defining AES_DEC_ABORT_EN.
module aes_decrypt_iter (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iStart,
`ifdef AES_DEC_ABORT_EN
    input  logic         iAbort,
`endif
    input  logic [127:0] iData,
    input  logic [127:0] iRoundKey,
    output logic [3:0]   oKeyIdx,
    output logic [127:0] oData,
    output logic         oValid,
    output logic         oBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ROUND = 2'b01,
        LAST  = 2'b10
    } fsm_t;

    fsm_t         fsm_r;
    logic [127:0] state_r;
    logic [3:0]   cnt_r;
    logic         abort_s;
    logic [127:0] sr_sb_s;
    logic [127:0] round_s;
    logic [127:0] final_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? t : 8'h00);
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x14, x15, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x14  = gf_mul(x12, x2);
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) begin
            x240 = gf_mul(x240, x240);
        end
        return gf_mul(x240, x14);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int j = 0; j < 16; j++) begin
            o[8*j +: 8] = inv_sbox(s[8*j +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[32*c + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

`ifdef AES_DEC_ABORT_EN
    assign abort_s = iAbort;
`else
    assign abort_s = 1'b0;
`endif

    // Round datapath; the last round shares the inverse shift/sub stage and skips InvMixColumns.
    always_comb begin
        sr_sb_s = inv_sub_bytes(inv_shift_rows(state_r));
        round_s = inv_mix_columns(sr_sb_s ^ iRoundKey);
        final_s = sr_sb_s ^ iRoundKey;
    end

    // Control FSM, state register and registered outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fsm_r   <= IDLE;
            state_r <= 128'h0;
            cnt_r   <= 4'd0;
            oKeyIdx <= 4'd10;
            oData   <= 128'h0;
            oValid  <= 1'b0;
            oBusy   <= 1'b0;
        end else if (abort_s) begin
            fsm_r   <= IDLE;
            state_r <= 128'h0;
            cnt_r   <= 4'd0;
            oKeyIdx <= 4'd10;
            oValid  <= 1'b0;
            oBusy   <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    oValid <= 1'b0;
                    if (iStart) begin
                        state_r <= iData ^ iRoundKey;
                        cnt_r   <= 4'd9;
                        oKeyIdx <= 4'd9;
                        oBusy   <= 1'b1;
                        fsm_r   <= ROUND;
                    end else begin
                        oKeyIdx <= 4'd10;
                        oBusy   <= 1'b0;
                        fsm_r   <= IDLE;
                    end
                end
                ROUND: begin
                    oValid  <= 1'b0;
                    state_r <= round_s;
                    cnt_r   <= cnt_r - 4'd1;
                    oKeyIdx <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        fsm_r <= LAST;
                    end else begin
                        fsm_r <= ROUND;
                    end
                end
                LAST: begin
                    oData   <= final_s;
                    oValid  <= 1'b1;
                    oBusy   <= 1'b0;
                    oKeyIdx <= 4'd10;
                    cnt_r   <= 4'd0;
                    fsm_r   <= IDLE;
                end
                default: begin
                    fsm_r   <= IDLE;
                    state_r <= 128'h0;
                    cnt_r   <= 4'd0;
                    oKeyIdx <= 4'd10;
                    oValid  <= 1'b0;
                    oBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_decrypt_iter.md
AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, fixed 10 rounds.
REQ-002 iClk  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 iRst  input  1  reset; synchronous, active-high.
REQ-004 iStart  input  1  start request; sampled only while oBusy=0.
REQ-005 iData  input  128  ciphertext, column-major: byte 4c+r (state row r, column c) at bits 8*(4c+r)+:8; byte 0 in bits [7:0].
REQ-006 iRoundKey  input  128  round key selected by oKeyIdx, same packing as iData, combinationally valid in the same cycle.
REQ-007 oKeyIdx  output  4  round-key index requested from the external key store, range 0..10.
REQ-008 oData  output  128  plaintext, same packing as iData.
REQ-009 oValid  output  1  one-cycle pulse; oData holds a new result.
REQ-010 oBusy  output  1  decryption in progress; iStart ignored while high.

Function
REQ-011 The block SHALL implement the FIPS-197 inverse cipher iteratively, one round per clock, on a 128-bit state register.
REQ-012 The FSM SHALL have states IDLE, ROUND and LAST; any unused encoding SHALL return to IDLE.
REQ-013 In IDLE, oKeyIdx SHALL equal 10; iStart=1 SHALL load state <= iData XOR iRoundKey, round counter <= 9, and move to ROUND.
REQ-014 In ROUND, oKeyIdx SHALL equal the round counter; each cycle state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), iRoundKey)), and the counter SHALL decrement.
REQ-015 ROUND SHALL execute for counter values 9 down to 1, then move to LAST.
REQ-016 In LAST, oKeyIdx SHALL equal 0; oData <= InvSubBytes(InvShiftRows(state)) XOR iRoundKey, oValid <= 1, next state IDLE.
REQ-017 InvShiftRows SHALL rotate row r right by r columns: out[r][c] = in[r][(c-r) mod 4].
REQ-018 InvMixColumns SHALL multiply each column by the matrix {0e,0b,0d,09} in GF(2^8), reduction polynomial 0x11B.
REQ-019 InvSubBytes SHALL apply the FIPS-197 inverse S-box to all 16 bytes in parallel; table or GF-inverse implementation is acceptable.
REQ-020 Latency: with iStart accepted in cycle T, oValid SHALL be high exactly in cycle T+11, and oBusy SHALL be high in cycles T+1..T+10.
REQ-021 oValid SHALL be high for one cycle only; oData SHALL hold its value until the next LAST cycle or reset.
REQ-022 iStart in the cycle where oValid=1 SHALL be accepted, because oBusy=0 in that cycle; back-to-back throughput is one block per 11 cycles.
REQ-023 iStart while oBusy=1 SHALL be ignored, with no effect on state, counter or outputs.
REQ-024 iData and iRoundKey SHALL be sampled only in the cycles defined above; changes at other times SHALL have no effect.

Reset
REQ-025 With iRst=1 at a clock edge: FSM=IDLE, oData=0, oValid=0, oBusy=0, oKeyIdx=10, state register=0, counter=0.
REQ-026 Reset SHALL override iStart, and iAbort when present.
REQ-027 Reset mid-operation SHALL discard the block: no oValid for it, and the next iStart starts cleanly.

Configuration
REQ-028 Macro AES_DEC_ABORT_EN SHALL add input port iAbort (1 bit).
REQ-029 With AES_DEC_ABORT_EN defined and iAbort=1 while oBusy=1: next cycle FSM=IDLE, state register=0, no oValid, oData unchanged.
REQ-030 With AES_DEC_ABORT_EN defined, iAbort=1 and iStart=1 together while idle: abort SHALL win and the start SHALL be ignored.
REQ-031 Without AES_DEC_ABORT_EN the port SHALL be absent and behaviour SHALL be as in REQ-011..REQ-027.

Verification
REQ-032 FIPS-197 C.1: key store expanded from key bytes 00 01 .. 0f, ciphertext bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a (byte 0 first) -> oValid at T+11, oData bytes 00 11 22 .. ff.
REQ-033 oKeyIdx trace over one block -> 10 (T), 9..1 (T+1..T+9), 0 (T+10), 10 (T+11).
REQ-034 Second iStart in the oValid cycle of the first block, then iStart pulses while busy -> exactly two oValid pulses, 11 cycles apart, both results correct.
REQ-035 iRst asserted at T+5 -> no oValid; all outputs at reset values; a following C.1 run passes.
REQ-036 AES_DEC_ABORT_EN defined: iAbort at T+4 -> oBusy=0 at T+5, no oValid, previous oData retained; iAbort+iStart together while idle -> no start.
REQ-037 Random ciphertext/key pairs checked against a reference model -> bit-exact oData in every case.
